// File: rtl/ysyx_23060075_csr_seq_pkg.sv
// Shared constants for the CSR access sequencer: CSR addresses, mstatus bit positions, op and state encodings.
// Defining YSYX_23060075_TRAP_MSTATUS_EN adds the mstatus save/restore states to the trap sequences.
package ysyx_23060075_csr_seq_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    typedef enum logic [2:0] {
        OP_CSRRW = 3'd0,
        OP_CSRRS = 3'd1,
        OP_CSRRC = 3'd2,
        OP_ECALL = 3'd3,
        OP_MRET  = 3'd4
    } csr_op_e;

`ifdef YSYX_23060075_TRAP_MSTATUS_EN
    typedef enum logic [3:0] {
        S_IDLE,
        S_EXEC,
        S_T_EPC,
        S_T_CAUSE,
        S_T_STAT,
        S_T_VEC,
        S_M_STAT,
        S_M_EPC,
        S_RESP
    } csr_state_e;
`else
    typedef enum logic [3:0] {
        S_IDLE,
        S_EXEC,
        S_T_EPC,
        S_T_CAUSE,
        S_T_VEC,
        S_M_EPC,
        S_RESP
    } csr_state_e;
`endif

endpackage

// File: rtl/ysyx_23060075_csr_seq_if.sv
// Request/response handshake between the execute stage (master) and the CSR sequencer (slave).
interface ysyx_23060075_csr_seq_if #(
    parameter int ISA_WIDTH      = 32,
    parameter int CSR_ADDR_WIDTH = 12
);
    logic                      req_valid;
    logic                      req_ready;
    logic [2:0]                req_op;
    logic [CSR_ADDR_WIDTH-1:0] req_addr;
    logic [ISA_WIDTH-1:0]      req_src;
    logic                      req_src_zero;
    logic [ISA_WIDTH-1:0]      req_pc;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [ISA_WIDTH-1:0]      rsp_rdata;
    logic                      rsp_jump;
    logic [ISA_WIDTH-1:0]      rsp_npc;

    modport master (
        output req_valid, req_op, req_addr, req_src, req_src_zero, req_pc, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_jump, rsp_npc
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_src, req_src_zero, req_pc, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_jump, rsp_npc
    );
endinterface

// File: rtl/ysyx_23060075_register.sv
// Generic enable-gated register with asynchronous active-low reset to a fixed value.
module ysyx_23060075_register #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wen_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            q_o <= RESET_VAL;
        end else if (wen_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/ysyx_23060075_csr_seq.sv
// CSR access sequencer: runs Zicsr read/modify/write and ECALL/MRET trap sequences over a single-port CSR file.
// Optional mstatus save/restore states are enabled by YSYX_23060075_TRAP_MSTATUS_EN.
module ysyx_23060075_csr_seq
    import ysyx_23060075_csr_seq_pkg::*;
#(
    parameter int ISA_WIDTH      = 32,
    parameter int CSR_ADDR_WIDTH = 12,
    parameter int ECALL_CAUSE    = 11
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    ysyx_23060075_csr_seq_if.slave    bus,
    output logic [CSR_ADDR_WIDTH-1:0] csr_addr_o,
    output logic [ISA_WIDTH-1:0]      csr_w_o,
    output logic                      csr_w_en_o,
    input  logic [ISA_WIDTH-1:0]      csr_r_i
);

    localparam int REQ_W = 3 + CSR_ADDR_WIDTH + 1 + 2 * ISA_WIDTH;

    csr_state_e                state_q;
    logic                      accept;
    logic [REQ_W-1:0]          req_q;
    logic [2:0]                op_q;
    logic [CSR_ADDR_WIDTH-1:0] addr_q;
    logic [ISA_WIDTH-1:0]      src_q;
    logic                      src_zero_q;
    logic [ISA_WIDTH-1:0]      pc_q;
    logic                      rdata_wen;
    logic [ISA_WIDTH-1:0]      rdata_d;
    logic [ISA_WIDTH-1:0]      rdata_q;
    logic                      jmp_wen;
    logic [ISA_WIDTH:0]        jmp_d;
    logic [ISA_WIDTH:0]        jmp_q;

`ifdef YSYX_23060075_TRAP_MSTATUS_EN
    function automatic logic [ISA_WIDTH-1:0] trap_mstatus(input logic [ISA_WIDTH-1:0] s);
        logic [ISA_WIDTH-1:0] r;
        r = s;
        r[MSTATUS_MPIE] = s[MSTATUS_MIE];
        r[MSTATUS_MIE] = 1'b0;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

    function automatic logic [ISA_WIDTH-1:0] mret_mstatus(input logic [ISA_WIDTH-1:0] s);
        logic [ISA_WIDTH-1:0] r;
        r = s;
        r[MSTATUS_MIE] = s[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b00;
        return r;
    endfunction
`endif

    assign accept = bus.req_valid && (state_q == S_IDLE);

    ysyx_23060075_register #(.WIDTH(REQ_W), .RESET_VAL('0)) u_req_reg (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .wen_i (accept),
        .d_i   ({bus.req_op, bus.req_addr, bus.req_src, bus.req_src_zero, bus.req_pc}),
        .q_o   (req_q)
    );

    assign {op_q, addr_q, src_q, src_zero_q, pc_q} = req_q;

    // Response fields are cleared on acceptance so reserved ops and CSR ops never leak a stale jump target.
    always_comb begin
        rdata_wen = accept || (state_q == S_EXEC);
        rdata_d   = (state_q == S_EXEC) ? csr_r_i : '0;
        jmp_wen   = accept || (state_q == S_T_VEC) || (state_q == S_M_EPC);
        jmp_d     = ((state_q == S_T_VEC) || (state_q == S_M_EPC)) ? {1'b1, csr_r_i} : '0;
    end

    ysyx_23060075_register #(.WIDTH(ISA_WIDTH), .RESET_VAL('0)) u_rdata_reg (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .wen_i (rdata_wen),
        .d_i   (rdata_d),
        .q_o   (rdata_q)
    );

    ysyx_23060075_register #(.WIDTH(ISA_WIDTH + 1), .RESET_VAL('0)) u_jmp_reg (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .wen_i (jmp_wen),
        .d_i   (jmp_d),
        .q_o   (jmp_q)
    );

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_jump  = jmp_q[ISA_WIDTH];
    assign bus.rsp_npc   = jmp_q[ISA_WIDTH-1:0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        case (bus.req_op)
                            OP_CSRRW, OP_CSRRS, OP_CSRRC: state_q <= S_EXEC;
                            OP_ECALL:                     state_q <= S_T_EPC;
`ifdef YSYX_23060075_TRAP_MSTATUS_EN
                            OP_MRET:                      state_q <= S_M_STAT;
`else
                            OP_MRET:                      state_q <= S_M_EPC;
`endif
                            default:                      state_q <= S_RESP;
                        endcase
                    end
                end
                S_EXEC:    state_q <= S_RESP;
                S_T_EPC:   state_q <= S_T_CAUSE;
`ifdef YSYX_23060075_TRAP_MSTATUS_EN
                S_T_CAUSE: state_q <= S_T_STAT;
                S_T_STAT:  state_q <= S_T_VEC;
                S_M_STAT:  state_q <= S_M_EPC;
`else
                S_T_CAUSE: state_q <= S_T_VEC;
`endif
                S_T_VEC:   state_q <= S_RESP;
                S_M_EPC:   state_q <= S_RESP;
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default:   state_q <= S_IDLE;
            endcase
        end
    end

    // CSR file drive depends only on the state and latched request; the RMW data folds in the live read.
    always_comb begin
        csr_addr_o = '0;
        csr_w_o    = '0;
        csr_w_en_o = 1'b0;
        case (state_q)
            S_EXEC: begin
                csr_addr_o = addr_q;
                case (op_q)
                    OP_CSRRW: begin
                        csr_w_o    = src_q;
                        csr_w_en_o = 1'b1;
                    end
                    OP_CSRRS: begin
                        csr_w_o    = csr_r_i | src_q;
                        csr_w_en_o = !src_zero_q;
                    end
                    OP_CSRRC: begin
                        csr_w_o    = csr_r_i & ~src_q;
                        csr_w_en_o = !src_zero_q;
                    end
                    default: ;
                endcase
            end
            S_T_EPC: begin
                csr_addr_o = CSR_ADDR_WIDTH'(CSR_MEPC);
                csr_w_o    = pc_q;
                csr_w_en_o = 1'b1;
            end
            S_T_CAUSE: begin
                csr_addr_o = CSR_ADDR_WIDTH'(CSR_MCAUSE);
                csr_w_o    = ISA_WIDTH'(ECALL_CAUSE);
                csr_w_en_o = 1'b1;
            end
`ifdef YSYX_23060075_TRAP_MSTATUS_EN
            S_T_STAT: begin
                csr_addr_o = CSR_ADDR_WIDTH'(CSR_MSTATUS);
                csr_w_o    = trap_mstatus(csr_r_i);
                csr_w_en_o = 1'b1;
            end
            S_M_STAT: begin
                csr_addr_o = CSR_ADDR_WIDTH'(CSR_MSTATUS);
                csr_w_o    = mret_mstatus(csr_r_i);
                csr_w_en_o = 1'b1;
            end
`endif
            S_T_VEC: csr_addr_o = CSR_ADDR_WIDTH'(CSR_MTVEC);
            S_M_EPC: csr_addr_o = CSR_ADDR_WIDTH'(CSR_MEPC);
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ysyx_23060075_csr_seq.sv
// Randomised self-checking bench for ysyx_23060075_csr_seq against a transaction-level CSR model.
// Honours YSYX_23060075_TRAP_MSTATUS_EN for expected latencies and mstatus updates.
module tb_ysyx_23060075_csr_seq;

    localparam logic [11:0] KNOWN_ADDR [5] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342};
    localparam int IDX_MSTATUS = 0;
    localparam int IDX_MTVEC   = 1;
    localparam int IDX_MEPC    = 3;
    localparam int IDX_MCAUSE  = 4;

    logic        clk;
    logic        rstN;
    logic [11:0] csrAddr;
    logic [31:0] csrW;
    logic        csrWEn;
    logic [31:0] csrR;

    logic [31:0] csrFile  [5] = '{default: 32'h0};
    logic [31:0] modelCsr [5] = '{default: 32'h0};
    int          totalWrites = 0;
    int          vectors = 0;
    int          miscompares = 0;

    ysyx_23060075_csr_seq_if #(.ISA_WIDTH(32), .CSR_ADDR_WIDTH(12)) bus ();

    ysyx_23060075_csr_seq #(.ISA_WIDTH(32), .CSR_ADDR_WIDTH(12), .ECALL_CAUSE(11)) dut (
        .clk_i     (clk),
        .rst_ni    (rstN),
        .bus       (bus),
        .csr_addr_o(csrAddr),
        .csr_w_o   (csrW),
        .csr_w_en_o(csrWEn),
        .csr_r_i   (csrR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int csrIndex(input logic [11:0] a);
        for (int k = 0; k < 5; k++) begin
            if (KNOWN_ADDR[k] == a) return k;
        end
        return -1;
    endfunction

    // Behavioural CSR file: combinational read, write on the rising edge, unknown addresses read 0.
    always_comb begin
        int ri;
        ri = csrIndex(csrAddr);
        csrR = (ri >= 0) ? csrFile[ri] : 32'h0;
    end

    always @(posedge clk) begin
        if (csrWEn) begin
            int wi;
            wi = csrIndex(csrAddr);
            if (wi >= 0) csrFile[wi] <= csrW;
            totalWrites++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

`ifdef YSYX_23060075_TRAP_MSTATUS_EN
    function automatic logic [31:0] trapStatus(input logic [31:0] s);
        return (s & ~32'h0000_1888) | (s[3] ? 32'h80 : 32'h0) | 32'h1800;
    endfunction

    function automatic logic [31:0] mretStatus(input logic [31:0] s);
        return (s & ~32'h0000_1888) | (s[7] ? 32'h8 : 32'h0) | 32'h80;
    endfunction
`endif

    // Transaction-level expectation: response values, cycles to rsp_valid and number of CSR writes issued.
    task automatic modelTxn(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] src,
                            input logic zero, input logic [31:0] pc,
                            output logic [31:0] eRdata, output logic eJump, output logic [31:0] eNpc,
                            output int eLat, output int eWrites);
        int          i;
        logic [31:0] old;
        eRdata = 32'h0; eJump = 1'b0; eNpc = 32'h0; eLat = 1; eWrites = 0;
        i = csrIndex(addr);
        old = (i >= 0) ? modelCsr[i] : 32'h0;
        case (op)
            3'd0: begin
                eRdata = old; eWrites = 1;
                if (i >= 0) modelCsr[i] = src;
            end
            3'd1: begin
                eRdata = old;
                if (!zero) begin
                    eWrites = 1;
                    if (i >= 0) modelCsr[i] = old | src;
                end
            end
            3'd2: begin
                eRdata = old;
                if (!zero) begin
                    eWrites = 1;
                    if (i >= 0) modelCsr[i] = old & ~src;
                end
            end
            3'd3: begin
                modelCsr[IDX_MEPC] = pc;
                modelCsr[IDX_MCAUSE] = 32'd11;
                eJump = 1'b1; eNpc = modelCsr[IDX_MTVEC];
`ifdef YSYX_23060075_TRAP_MSTATUS_EN
                modelCsr[IDX_MSTATUS] = trapStatus(modelCsr[IDX_MSTATUS]);
                eWrites = 3; eLat = 4;
`else
                eWrites = 2; eLat = 3;
`endif
            end
            3'd4: begin
                eJump = 1'b1; eNpc = modelCsr[IDX_MEPC];
`ifdef YSYX_23060075_TRAP_MSTATUS_EN
                modelCsr[IDX_MSTATUS] = mretStatus(modelCsr[IDX_MSTATUS]);
                eWrites = 1; eLat = 2;
`else
                eWrites = 0; eLat = 1;
`endif
            end
            default: eLat = 0;
        endcase
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " req_ready"}, 32'(bus.req_ready), 32'h1);
        checkOutput({tag, " rsp_valid"}, 32'(bus.rsp_valid), 32'h0);
        checkOutput({tag, " rsp_jump"}, 32'(bus.rsp_jump), 32'h0);
        checkOutput({tag, " rsp_rdata"}, bus.rsp_rdata, 32'h0);
        checkOutput({tag, " rsp_npc"}, bus.rsp_npc, 32'h0);
        checkOutput({tag, " csr_w_en"}, 32'(csrWEn), 32'h0);
        checkOutput({tag, " csr_addr"}, 32'(csrAddr), 32'h0);
        checkOutput({tag, " csr_w"}, csrW, 32'h0);
    endtask

    task automatic waitIdle(input string tag);
        int waitCnt;
        waitCnt = 0;
        while (!bus.req_ready && waitCnt < 20) begin
            @(posedge clk); #1;
            waitCnt++;
        end
        checkOutput({tag, " idle"}, 32'(bus.req_ready), 32'h1);
    endtask

    task automatic drive(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] src,
                         input logic zero, input logic [31:0] pc);
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_addr = addr;
        bus.req_src = src; bus.req_src_zero = zero; bus.req_pc = pc;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic applyStimulus(input string tag, input logic [2:0] op, input logic [11:0] addr,
                                 input logic [31:0] src, input logic zero, input logic [31:0] pc, input int hold);
        logic [31:0] eRdata, eNpc;
        logic        eJump;
        int          eLat, eWrites, lat, startWrites;
        modelTxn(op, addr, src, zero, pc, eRdata, eJump, eNpc, eLat, eWrites);
        waitIdle(tag);
        startWrites = totalWrites;
        drive(op, addr, src, zero, pc);
        lat = 0;
        while (!bus.rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput({tag, " latency"}, 32'(lat), 32'(eLat));
        checkOutput({tag, " rdata"}, bus.rsp_rdata, eRdata);
        checkOutput({tag, " jump"}, 32'(bus.rsp_jump), 32'(eJump));
        checkOutput({tag, " npc"}, bus.rsp_npc, eNpc);
        checkOutput({tag, " writes"}, 32'(totalWrites - startWrites), 32'(eWrites));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            checkOutput({tag, " hold valid"}, 32'(bus.rsp_valid), 32'h1);
            checkOutput({tag, " hold npc"}, bus.rsp_npc, eNpc);
            checkOutput({tag, " hold rdata"}, bus.rsp_rdata, eRdata);
            checkOutput({tag, " hold req_ready"}, 32'(bus.req_ready), 32'h0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        checkOutput({tag, " rsp_valid drop"}, 32'(bus.rsp_valid), 32'h0);
        checkOutput({tag, " back to idle"}, 32'(bus.req_ready), 32'h1);
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("%s csr[%03h]", tag, KNOWN_ADDR[k]), csrFile[k], modelCsr[k]);
        end
    endtask

    // Abort an ECALL while it is writing mcause; mepc is already committed, mcause must stay untouched.
    task automatic resetMidTrap(input logic [31:0] pc);
        int startWrites;
        waitIdle("rst_mid");
        startWrites = totalWrites;
        drive(3'd3, 12'h000, 32'h0, 1'b0, pc);
        @(posedge clk); #1;
        checkOutput("rst_mid cause addr", 32'(csrAddr), 32'h342);
        checkOutput("rst_mid cause wen", 32'(csrWEn), 32'h1);
        rstN = 1'b0;
        #1;
        checkResetOutputs("rst_mid");
        modelCsr[IDX_MEPC] = pc;
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk); #1;
        checkOutput("rst_mid writes", 32'(totalWrites - startWrites), 32'h1);
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("rst_mid csr[%03h]", KNOWN_ADDR[k]), csrFile[k], modelCsr[k]);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [2:0]  rop;
        logic [11:0] raddr;
        int          pick;
        rstN = 1'b0;
        bus.req_valid = 1'b0; bus.req_op = 3'd0; bus.req_addr = 12'h0;
        bus.req_src = 32'h0; bus.req_src_zero = 1'b0; bus.req_pc = 32'h0; bus.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk); #1;

        applyStimulus("rw_mtvec", 3'd0, 12'h305, 32'h8000_0100, 1'b0, 32'h8000_0000, 0);
        applyStimulus("rw_mstatus", 3'd0, 12'h300, 32'h0000_1800, 1'b0, 32'h8000_0004, 0);
        applyStimulus("rs_mstatus", 3'd1, 12'h300, 32'h0000_0008, 1'b0, 32'h8000_0008, 1);
        applyStimulus("rs_zero", 3'd1, 12'h300, 32'h0000_0008, 1'b1, 32'h8000_000c, 0);
        applyStimulus("rc_mstatus", 3'd2, 12'h300, 32'h0000_0800, 1'b0, 32'h8000_0010, 0);
        applyStimulus("ecall", 3'd3, 12'h000, 32'h0, 1'b0, 32'h8000_0040, 0);
        applyStimulus("rw_mepc", 3'd0, 12'h341, 32'h8000_0044, 1'b0, 32'h8000_0100, 0);
        applyStimulus("mret_hold", 3'd4, 12'h000, 32'h0, 1'b0, 32'h8000_0104, 5);
        applyStimulus("reserved", 3'd6, 12'h305, 32'hdead_beef, 1'b0, 32'h8000_0108, 1);
        applyStimulus("rw_unknown", 3'd0, 12'h7c0, 32'h1234_5678, 1'b0, 32'h8000_010c, 0);
        applyStimulus("rw_mcause", 3'd0, 12'h342, 32'h0000_005a, 1'b0, 32'h8000_0110, 0);
        resetMidTrap(32'h8000_0080);
        applyStimulus("after_rst", 3'd1, 12'h342, 32'h0000_0100, 1'b0, 32'h8000_0114, 0);

        for (int n = 0; n < 40; n++) begin
            pick = $urandom_range(0, 9);
            case (pick)
                0, 1, 9: rop = 3'd0;
                2, 3:    rop = 3'd1;
                4, 5:    rop = 3'd2;
                6:       rop = 3'd3;
                7:       rop = 3'd4;
                default: rop = 3'($urandom_range(5, 7));
            endcase
            pick = $urandom_range(0, 5);
            raddr = (pick < 5) ? KNOWN_ADDR[pick] : 12'(12'h7c0 + $urandom_range(0, 15));
            applyStimulus($sformatf("rand%0d", n), rop, raddr, $urandom(), 1'($urandom_range(0, 1)),
                          $urandom() & 32'hffff_fffc, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ysyx_23060075_csr_seq.md
Name: ysyx_23060075_csr_seq

Overview:
CSR access initiator between the execute stage and the CSR register file. Accepts one Zicsr/trap request per handshake and sequences single-port CSR reads and writes over the file's addr/wdata/w_en/rdata interface. Returns the old CSR value for rd, or a redirect PC for ECALL/MRET. Register-file read is combinational; writes commit on the rising edge.

Parameters:
ISA_WIDTH, 32, data/PC width
CSR_ADDR_WIDTH, 12, CSR address width
ECALL_CAUSE, 11, mcause value written on ECALL (M-mode environment call)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
req_valid  in  1  request valid
req_ready  out  1  block can accept a request
req_op  in  3  0=CSRRW 1=CSRRS 2=CSRRC 3=ECALL 4=MRET; 5-7 reserved
req_addr  in  CSR_ADDR_WIDTH  target CSR (CSR ops only)
req_src  in  ISA_WIDTH  rs1 value or zimm
req_src_zero  in  1  rs1 index / zimm is zero (suppresses write for S/C)
req_pc  in  ISA_WIDTH  PC of the instruction
rsp_valid  out  1  response valid
rsp_ready  in  1  consumer accepts response
rsp_rdata  out  ISA_WIDTH  old CSR value (CSR ops), 0 otherwise
rsp_jump  out  1  1 for ECALL/MRET
rsp_npc  out  ISA_WIDTH  redirect target when rsp_jump
csr_addr  out  CSR_ADDR_WIDTH  to CSR file
csr_w  out  ISA_WIDTH  write data to CSR file
csr_w_en  out  1  write enable to CSR file
csr_r  in  ISA_WIDTH  combinational read data from CSR file

Behaviour:
- Reset (rst=0, async): state IDLE. req_ready=1. rsp_valid=0, rsp_jump=0, rsp_rdata=0, rsp_npc=0, csr_w_en=0, csr_addr=0, csr_w=0.
- Request latch: req_ready=1 only in IDLE. On req_valid&req_ready, op/addr/src/src_zero/pc are registered. Outputs to the CSR file are driven only from registered values.
- States: IDLE, EXEC, T_EPC, T_CAUSE, T_VEC, M_EPC, RESP.
- IDLE transitions: CSR op -> EXEC; ECALL -> T_EPC; MRET -> M_EPC.
- Reserved op: goes straight to RESP with rdata=0, jump=0. No CSR access.
- EXEC (1 cycle): csr_addr=addr; capture csr_r into rsp_rdata.
  - CSRRW: csr_w=src, csr_w_en=1 (always).
  - CSRRS: csr_w=csr_r|src; csr_w_en=!src_zero.
  - CSRRC: csr_w=csr_r&~src; csr_w_en=!src_zero.
  - -> RESP.
- ECALL:
  - T_EPC: addr=MEPC, w=pc, w_en=1.
  - T_CAUSE: addr=MCAUSE, w=ECALL_CAUSE zero-extended, w_en=1.
  - T_VEC: addr=MTVEC, w_en=0, rsp_npc<=csr_r, rsp_jump<=1.
  - -> RESP.
- MRET:
  - M_EPC: addr=MEPC, w_en=0, rsp_npc<=csr_r, rsp_jump<=1.
  - -> RESP.
- RESP: rsp_valid=1. Data stays stable until rsp_ready; on rsp_valid&rsp_ready -> IDLE. No new request is accepted in the same cycle (req_ready goes high the cycle after).
- csr_w_en is 0 in every state not listed above as writing.
- Latency, request accepted at edge T:
  - CSR op: rsp_valid from T+1 (EXEC during T..T+1, RESP after).
  - ECALL: rsp_valid 3 cycles after acceptance.
  - MRET: rsp_valid 1 cycle after acceptance.
- Unknown CSR address: the file returns 0, so rdata=0; the write is still issued (the file ignores it).
- Reset mid-sequence: abort immediately to the reset values. A partially completed trap may leave mepc written without mcause; this is accepted.

Optional Feature:
YSYX_23060075_TRAP_MSTATUS_EN.
- Defined:
  - ECALL adds state T_STAT after T_CAUSE: addr=MSTATUS, read-modify-write MPIE(bit7)<=MIE(bit3), MIE<=0, MPP(bits12:11)<=2'b11. ECALL latency becomes 4.
  - MRET adds M_STAT before M_EPC: MIE<=MPIE, MPIE<=1, MPP<=2'b00. MRET latency becomes 2.
- Undefined: states absent; mstatus is never written by this block.

Decomposition:
- Shared config header: CSR address constants (MEPC, MCAUSE, MTVEC, MSTATUS), mstatus bit positions, op encodings, state encodings.
- No sub-module needed. Reuse the existing ysyx_23060075_register for the latched request and response fields. The FSM stays in the top.

Test Plan:
- CSRRW addr=MTVEC, src=0x80000100, mtvec=0 -> rdata=0, mtvec=0x80000100, rsp_valid 1 cycle after accept, rsp_jump=0.
- CSRRS addr=MSTATUS, src=0x8, src_zero=0, mstatus=0x1800 -> rdata=0x1800, mstatus=0x1808. Repeat with src_zero=1 -> csr_w_en never asserted.
- CSRRC addr=MSTATUS, src=0x800, mstatus=0x1808 -> rdata=0x1808, mstatus=0x1008.
- ECALL pc=0x80000040, mtvec=0x80000100 -> mepc=0x80000040, mcause=11, rsp_jump=1, rsp_npc=0x80000100, latency 3 (4 with macro).
- MRET with mepc=0x80000044, rsp_ready held low 5 cycles -> rsp_valid and rsp_npc=0x80000044 stable, req_ready=0 throughout. rsp_ready=1 returns to IDLE.
- Assert rst=0 during T_CAUSE -> all outputs return to reset values asynchronously; mcause unchanged; the next request proceeds normally.
